// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: op codes, FSM states, counter sizing.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  // Step counter must hold the value N itself, hence the extra bit.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

  localparam int N_DEFAULT     = 32;
  localparam int CNT_W_DEFAULT = cnt_width(N_DEFAULT);

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Handshake and result bundle between the ID/EX pipeline register and the multiply/divide unit.
interface ex_muldiv_unit_if #(parameter int N = 32);
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] operand_a;
  logic [N-1:0] operand_b;
  logic         flush;
  logic         busy;
  logic         stall;
  logic         done;
  logic         div_by_zero;
  logic [N-1:0] hi_out;
  logic [N-1:0] lo_out;

  modport master (
    output start, op, operand_a, operand_b, flush,
    input  busy, stall, done, div_by_zero, hi_out, lo_out
  );

  modport slave (
    input  start, op, operand_a, operand_b, flush,
    output busy, stall, done, div_by_zero, hi_out, lo_out
  );
endinterface

// File: rtl/ex_muldiv_unit_core.sv
// One radix-2 step of the multiply/divide datapath; purely combinational next-value logic.
module muldiv_core #(
  parameter int N = 32
) (
  input  logic           is_div,
  input  logic [2*N-1:0] acc,
  input  logic [2*N-1:0] mcand,
  input  logic [N-1:0]   mplier,
  output logic [2*N-1:0] acc_next,
  output logic [2*N-1:0] mcand_next,
  output logic [N-1:0]   mplier_next
);

  logic [N:0] shifted;
  logic [N:0] diff;

  // Divide keeps {remainder, dividend/quotient} in acc and the divisor in mcand[N-1:0].
  // Multiply adds a left-shifting multiplicand, so the product is always aligned.
  always_comb begin
    acc_next    = acc;
    mcand_next  = mcand;
    mplier_next = mplier;
    shifted     = {acc[2*N-1:N], acc[N-1]};
    diff        = shifted - {1'b0, mcand[N-1:0]};
    if (is_div) begin
      if (!diff[N]) begin
        acc_next = {diff[N-1:0], acc[N-2:0], 1'b1};
      end else begin
        acc_next = {shifted[N-1:0], acc[N-2:0], 1'b0};
      end
    end else begin
      if (mplier[0]) begin
        acc_next = acc + mcand;
      end
      mcand_next  = {mcand[2*N-2:0], 1'b0};
      mplier_next = {1'b0, mplier[N-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU unit owning HI/LO and the pipeline stall.
// Build option MULDIV_EARLY_EXIT_EN: multiplies leave RUN once the remaining multiplier bits are zero.
//
// state   | meaning
// ST_IDLE | waiting for start; HI/LO hold the last result
// ST_RUN  | one radix-2 step per cycle, step counter runs down to 1
// ST_FIX  | sign correction and HI/LO write; done pulses the cycle after
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int N = 32
) (
  input logic          clk,
  input logic          reset,
  ex_muldiv_unit_if.slave bus
);

  localparam int CW = cnt_width(N);

  state_e         state;
  state_e         state_next;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] mcand;
  logic [N-1:0]   mplier;
  logic [2*N-1:0] acc_step;
  logic [2*N-1:0] mcand_step;
  logic [N-1:0]   mplier_step;
  logic           is_div;
  logic           neg_res;
  logic           neg_rem;
  logic           dz;
  logic [N-1:0]   hi_q;
  logic [N-1:0]   lo_q;
  logic           done_q;
  logic           dz_out_q;

  op_e            op_in;
  logic           op_div;
  logic           op_signed;
  logic           sign_a;
  logic           sign_b;
  logic [N-1:0]   abs_a;
  logic [N-1:0]   abs_b;
  logic           b_zero;
  logic           accept;
  logic           mult_zero_skip;
  logic           early_exit;
  logic           run_last;
  logic           busy;
  logic [2*N-1:0] prod_fix;
  logic [N-1:0]   quo;
  logic [N-1:0]   rem;

  assign op_in     = op_e'(bus.op);
  assign op_div    = (op_in == OP_DIV) || (op_in == OP_DIVU);
  assign op_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign sign_a    = op_signed & bus.operand_a[N-1];
  assign sign_b    = op_signed & bus.operand_b[N-1];
  assign abs_a     = sign_a ? -bus.operand_a : bus.operand_a;
  assign abs_b     = sign_b ? -bus.operand_b : bus.operand_b;
  assign b_zero    = (bus.operand_b == '0);

  // A completing op raises done for one cycle; start seen then belongs to the same instruction.
  assign accept = (state == ST_IDLE) & bus.start & ~done_q & ~bus.flush;

`ifdef MULDIV_EARLY_EXIT_EN
  assign mult_zero_skip = ~op_div & b_zero;
  assign early_exit     = ~is_div & (mplier_step == '0);
`else
  assign mult_zero_skip = 1'b0;
  assign early_exit     = 1'b0;
`endif

  assign run_last = (cnt == CW'(1)) | early_exit;

  muldiv_core #(.N(N)) u_core (
    .is_div      (is_div),
    .acc         (acc),
    .mcand       (mcand),
    .mplier      (mplier),
    .acc_next    (acc_step),
    .mcand_next  (mcand_step),
    .mplier_next (mplier_step)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (b_zero & (op_div | mult_zero_skip)) begin
            state_next = ST_FIX;
          end else begin
            state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (bus.flush) begin
          state_next = ST_IDLE;
        end else if (run_last) begin
          state_next = ST_FIX;
        end
      end
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign prod_fix = neg_res ? -acc : acc;
  assign quo      = acc[N-1:0];
  assign rem      = acc[2*N-1:N];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      dz       <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_out_q <= 1'b0;
    end else begin
      done_q   <= (state == ST_FIX) & ~bus.flush;
      dz_out_q <= (state == ST_FIX) & ~bus.flush & dz;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            is_div  <= op_div;
            neg_res <= sign_a ^ sign_b;
            neg_rem <= sign_a;
            dz      <= op_div & b_zero;
            cnt     <= CW'(N);
            mplier  <= abs_b;
            mcand   <= {{N{1'b0}}, (op_div ? abs_b : abs_a)};
            // Zero divisor skips RUN; stash the raw dividend and all-ones quotient for FIX.
            if (op_div & b_zero) begin
              acc <= {bus.operand_a, {N{1'b1}}};
            end else if (op_div) begin
              acc <= {{N{1'b0}}, abs_a};
            end else begin
              acc <= '0;
            end
          end
        end
        ST_RUN: begin
          acc    <= acc_step;
          mcand  <= mcand_step;
          mplier <= mplier_step;
          cnt    <= cnt - CW'(1);
        end
        ST_FIX: begin
          if (!bus.flush) begin
            if (dz) begin
              hi_q <= acc[2*N-1:N];
              lo_q <= acc[N-1:0];
            end else if (is_div) begin
              hi_q <= neg_rem ? -rem : rem;
              lo_q <= neg_res ? -quo : quo;
            end else begin
              hi_q <= prod_fix[2*N-1:N];
              lo_q <= prod_fix[N-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy            = (state != ST_IDLE);
  assign bus.busy        = busy;
  assign bus.stall       = busy | (bus.start & ~done_q & ~bus.flush);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_out_q;
  assign bus.hi_out      = hi_q;
  assign bus.lo_out      = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: 64-bit arithmetic reference model, decoupled done monitor.
module tb_ex_muldiv_unit;
  localparam int N = 32;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  ex_muldiv_unit_if #(.N(N)) bus ();
  ex_muldiv_unit #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] exp;
  } chk_t;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  chk_t        chk_q[$];
  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  // Only the monitor below touches the counters.
  function automatic void cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    chk_q.push_back(c);
  endfunction

  always @(negedge clk) begin
    chk_t c;
    exp_t e;
    while (chk_q.size() != 0) begin
      c = chk_q.pop_front();
      cmp(c.name, c.act, c.exp);
    end
    if (reset === 1'b0 && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        cmp("unexpected_done", 64'(bus.done), 64'd0);
      end else begin
        e = exp_q.pop_front();
        cmp({e.name, "_hi"}, 64'(bus.hi_out), 64'(e.hi));
        cmp({e.name, "_lo"}, 64'(bus.lo_out), 64'(e.lo));
        cmp({e.name, "_dz"}, 64'(bus.div_by_zero), 64'(e.dz));
        cmp({e.name, "_done_cycle"}, 64'(cyc), 64'(e.cyc));
      end
    end else if (reset === 1'b0 && bus.div_by_zero === 1'b1) begin
      cmp("dz_without_done", 64'(bus.div_by_zero), 64'd0);
    end
  end

  // Reference: plain 64-bit integer arithmetic; cycles from start edge to done cycle.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo,
                                output logic dz, output int lat);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     v;
    logic [31:0]     mb;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    dz  = 1'b0;
    lat = N + 2;
    v   = '0;
    case (o)
      2'b00: v = sa * sb;
      2'b01: v = ua * ub;
      default: begin
        if (b == 32'd0) begin
          v   = {a, 32'hFFFF_FFFF};
          dz  = 1'b1;
          lat = 2;
        end else if (o == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          v = {r[31:0], q[31:0]};
        end else begin
          q = longint'(ua / ub);
          r = longint'(ua % ub);
          v = {r[31:0], q[31:0]};
        end
      end
    endcase
`ifdef MULDIV_EARLY_EXIT_EN
    if (!o[1]) begin
      mb  = (o == 2'b00 && b[31]) ? -b : b;
      lat = 2;
      for (int i = 0; i < 32; i++) if (mb[i]) lat = 3 + i;
    end
`else
    mb = b;
`endif
    hi = v[63:32];
    lo = v[31:0];
  endfunction

  // Issues one instruction and holds start like a stalled ID/EX register until done.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input string name);
    exp_t        e;
    logic [31:0] h, l;
    logic        dz;
    int          lat;
    bit          seen;
    model(o, a, b, h, l, dz, lat);
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.op        = o;
    bus.operand_a = a;
    bus.operand_b = b;
    e.name = name;
    e.hi   = h;
    e.lo   = l;
    e.dz   = dz;
    e.cyc  = cyc + lat;
    exp_q.push_back(e);
    last_hi = h;
    last_lo = l;
    seen = 1'b0;
    for (int t = 0; t < 80 && !seen; t++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        chk({name, "_stall_in_done"}, 64'(bus.stall), 64'd0);
        seen = 1'b1;
      end else begin
        chk({name, "_stall"}, 64'(bus.stall), 64'd1);
      end
    end
    if (!seen) chk({name, "_timeout"}, 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 300));
      5: return 32'($urandom_range(0, 255)) << $urandom_range(0, 24);
      default: return $urandom;
    endcase
  endfunction

  logic [1:0]  r_op;
  logic [31:0] r_a, r_b;

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.op        = 2'b00;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.flush     = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy",  64'(bus.busy), 64'd0);
    chk("rst_done",  64'(bus.done), 64'd0);
    chk("rst_dz",    64'(bus.div_by_zero), 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'd0);
    chk("rst_hi",    64'(bus.hi_out), 64'd0);
    chk("rst_lo",    64'(bus.lo_out), 64'd0);

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    issue(2'b00, 32'hFFFF_FFF9, 32'd3,         "mult_neg7x3");
    issue(2'b10, 32'hFFFF_FFF9, 32'd2,         "div_neg7d2");
    issue(2'b11, 32'd100,       32'd7,         "divu_100d7");
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_minneg");
    issue(2'b11, 32'd5,         32'd0,         "divu_by0");
    issue(2'b10, 32'hFFFF_FFF0, 32'd0,         "div_by0_neg");
    issue(2'b01, 32'd9,         32'd1,         "multu_9x1");
    issue(2'b00, 32'd12345,     32'd0,         "mult_by0");
    issue(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_minsq");
    issue(2'b10, 32'd7,         32'hFFFF_FFFE, "div_7dneg2");

    // flush together with start while idle must not launch anything
    @(posedge clk); #1;
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b01;
    bus.operand_a = 32'd3; bus.operand_b = 32'd4;
    @(negedge clk);
    chk("flush_start_stall", 64'(bus.stall), 64'd0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_start_busy", 64'(bus.busy), 64'd0);

    // flush ten cycles into a divide: abort, HI/LO untouched, no done
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 2'b11;
    bus.operand_a = 32'd1234567; bus.operand_b = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1; bus.start = 1'b0;
    @(negedge clk);
    chk("flush_busy_before", 64'(bus.busy), 64'd1);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_busy_after", 64'(bus.busy), 64'd0);
    chk("flush_hi_kept",    64'(bus.hi_out), 64'(last_hi));
    chk("flush_lo_kept",    64'(bus.lo_out), 64'(last_lo));
    repeat (40) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = pick();
      r_b  = pick();
      issue(r_op, r_a, r_b, $sformatf("rand%0d_op%0d", i, r_op));
    end

    // synchronous reset in the middle of RUN clears everything on the next edge
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 2'b00;
    bus.operand_a = 32'h1234_5678; bus.operand_b = 32'hFFFF_F000;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1; bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy",  64'(bus.busy), 64'd0);
    chk("midrst_done",  64'(bus.done), 64'd0);
    chk("midrst_dz",    64'(bus.div_by_zero), 64'd0);
    chk("midrst_stall", 64'(bus.stall), 64'd0);
    chk("midrst_hi",    64'(bus.hi_out), 64'd0);
    chk("midrst_lo",    64'(bus.lo_out), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    last_hi = '0;
    last_lo = '0;
    issue(2'b01, 32'd6, 32'd7, "post_reset_multu");

    repeat (5) @(negedge clk);
    chk("pending_results", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected end of test", cyc);
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- EX-stage iterative multiply/divide unit. It consumes the operands and decoded op held in the ID/EX pipeline register.
- Owns the HI/LO result registers.
- Drives a stall back to the IF/ID and ID/EX registers while an operation is in flight.
- Runs MULT, MULTU, DIV and DIVU in one radix-2 step per cycle. The rest of the pipeline stays single-cycle.

Parameters:
- N, 32, operand width. HI and LO are each N bits. The step counter is $clog2(N)+1 bits.

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  synchronous, active-high
- start  input  1  EX holds a mult/div instruction (from ID/EX control)
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- operand_a  input  N  rs value (ID/EX Data_1_out)
- operand_b  input  N  rt value (ID/EX Data_2_out)
- flush  input  1  abort the operation in flight (branch/jump squash)
- busy  output  1  operation in flight
- stall  output  1  hold IF/ID and ID/EX; combinational
- done  output  1  one-cycle pulse; HI/LO just updated
- div_by_zero  output  1  qualifies done; the divide had a zero divisor
- hi_out  output  N  HI register (product upper half / remainder)
- lo_out  output  N  LO register (product lower half / quotient)

Behaviour:
- Clock and reset: single clock. Reset is synchronous and active-high.
- Reset values: state IDLE, busy 0, done 0, div_by_zero 0, hi_out 0, lo_out 0, counter 0. Reset overrides every other input, including in the middle of an operation.
- State machine states: IDLE, RUN, FIX.
  - IDLE -> RUN when start=1 and done=0. On that edge, latch op, |a|, |b| and both sign bits. Signed ops take the absolute value; unsigned ops use the raw value.
  - IDLE -> FIX instead, when the op is DIV/DIVU and operand_b==0.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. Exactly N cycles, then go to FIX.
  - FIX: one cycle. Apply the sign correction, write HI/LO, return to IDLE. done=1 in the following cycle.
- Latency: start sampled at edge k.
  - busy=1 for cycles k+1 .. k+N+1.
  - HI/LO and done are valid in cycle k+N+2.
  - Divide by zero: busy for 1 cycle; done in cycle k+2.
- Stall: stall = busy | (start & ~done & ~flush). The issuing instruction advances in the done cycle. start is ignored while done=1, so the same instruction cannot re-issue.
- start while busy: ignored. No queueing.
- Sign rules:
  - MULT: negate the 2N-bit product when the operand signs differ.
  - DIV: negate the quotient when the signs differ. The remainder takes the dividend's sign.
  - Most-negative / -1 gives quotient 0x80000000 (wraps) and remainder 0. No exception.
- Divide by zero: hi_out = operand_a, lo_out = all ones, div_by_zero=1 together with done.
- flush while busy: return to IDLE on the next edge. HI/LO unchanged, no done pulse.
- flush together with start in IDLE: start is not accepted.
- done and div_by_zero are registered pulses. They deassert after one cycle.

Optional Feature:
- Macro: MULDIV_EARLY_EXIT_EN.
- When defined: a multiply leaves RUN as soon as the remaining multiplier bits are all zero, after aligning the partial product. Latency becomes 2 + (index of the highest set bit of |b|, plus 1). Multiply by 0 or 1 completes in 2 or 3 cycles. Divide latency is unchanged.
- When undefined: fixed N-cycle RUN for every operation.
- Stall/done protocol is identical in both builds.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
  - state encoding (ST_IDLE, ST_RUN, ST_FIX)
  - a localparam for the counter width function
- Sub-module muldiv_core: the per-cycle step datapath (accumulator, shifter, subtractor). It is purely combinational next-state logic.
- ex_muldiv_unit keeps the FSM, counter, sign latch, HI/LO registers and stall logic.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done in cycle k+34; hi=0xFFFFFFFE, lo=0x00000001; stall high cycles k..k+33.
- MULT a=-7 (0xFFFFFFF9), b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=100, b=7 -> lo=14, hi=2.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU a=5, b=0 -> done in cycle k+2, div_by_zero=1, hi=5, lo=0xFFFFFFFF.
- Cycle 10 after start: assert flush -> busy=0 next cycle, no done, HI/LO keep prior values. Then assert reset mid-RUN -> all outputs 0 next cycle.
- start held high across the done cycle -> exactly one operation and one done pulse. With MULDIV_EARLY_EXIT_EN defined, MULTU a=9, b=1 -> done in cycle k+3, lo=9.
